// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end with an on-board program memory.
//
// A program is written into the 2^AW x 9 memory while the unit is idle or
// halted. A start pulse begins execution at address 0: each instruction is
// fetched into DIN with Run raised, held until the processor reports done,
// and then pc advances (or jumps). Fetching HALT_WORD stops execution.
//
// Ports:
//   clk        rising-edge clock
//   Resetn     synchronous active-low reset (memory contents are preserved)
//   load_en    program-load write strobe (honoured only in IDLE/HALT)
//   load_addr  program-load word address
//   load_data  program-load instruction word
//   start      begin execution from address 0 (honoured only in IDLE/HALT)
//   done       processor finished the current instruction (EXEC only)
//   jmp        current instruction is a taken jump (sampled with done)
//   jmp_addr   jump target (sampled with done)
//   DIN        instruction word presented to the processor
//   Run        DIN holds a valid instruction being executed
//   pc         address of the instruction in DIN
//   halted     HALT_WORD has been fetched
//   busy       unit is in FETCH or EXEC
//   icount     retired-instruction count, saturating at 255

module fetch_unit #(
    parameter int unsigned AW        = 6,
    parameter logic [8:0]  HALT_WORD = 9'b100000000
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [8:0]    load_data,
    input  logic          start,
    input  logic          done,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_addr,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          busy,
    output logic [7:0]    icount
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [8:0] mem [DEPTH];
    logic [8:0] fetch_word;
    logic       stopped;

    assign fetch_word = mem[pc];
    assign stopped    = (state == IDLE) || (state == HALT);
    assign busy       = (state == FETCH) || (state == EXEC);

    // Program memory: no reset, so a program survives Resetn. Writes are
    // locked out while executing so the running program cannot be altered.
    always_ff @(posedge clk) begin
        if (load_en && stopped) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = (fetch_word == HALT_WORD) ? HALT : EXEC;
            end
            EXEC: begin
                if (done) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            pc     <= '0;
            DIN    <= '0;
            Run    <= 1'b0;
            halted <= 1'b0;
            icount <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc     <= '0;
                        icount <= '0;
                        halted <= 1'b0;
                    end
                end
                FETCH: begin
                    DIN <= fetch_word;
                    if (fetch_word == HALT_WORD) begin
                        halted <= 1'b1;
                    end else begin
                        Run <= 1'b1;
                    end
                end
                EXEC: begin
                    if (done) begin
                        Run <= 1'b0;
                        if (icount != 8'hFF) begin
                            icount <= icount + 8'd1;
                        end
                        // pc + 1 wraps naturally at the AW-bit width.
                        pc <= jmp ? jmp_addr : pc + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (default
// parameters). Inputs change 1 ns after a rising edge; outputs are checked
// at that same point, well clear of the next edge.

module tb_fetch_unit;

    localparam int unsigned AW = 6;
    localparam logic [8:0]  HW = 9'b100000000;

    logic          clk = 1'b0;
    logic          Resetn = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [8:0]    load_data = '0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic          jmp = 1'b0;
    logic [AW-1:0] jmp_addr = '0;
    logic [8:0]    DIN;
    logic          Run;
    logic [AW-1:0] pc;
    logic          halted;
    logic          busy;
    logic [7:0]    icount;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.AW(AW), .HALT_WORD(HW)) dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .done      (done),
        .jmp       (jmp),
        .jmp_addr  (jmp_addr),
        .DIN       (DIN),
        .Run       (Run),
        .pc        (pc),
        .halted    (halted),
        .busy      (busy),
        .icount    (icount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered with the unit in FETCH; leaves it in FETCH (or HALT next).
    task automatic run_instr(input string tag, input logic [8:0] d, input logic [AW-1:0] p,
                             input logic j, input logic [AW-1:0] ja);
        step();
        check({tag, "_run"}, 32'(Run), 1);
        check({tag, "_din"}, 32'(DIN), 32'(d));
        check({tag, "_pc"}, 32'(pc), 32'(p));
        step();
        step();
        check({tag, "_hold"}, 32'({Run, DIN}), 32'({1'b1, d}));
        done     = 1'b1;
        jmp      = j;
        jmp_addr = ja;
        step();
        done     = 1'b0;
        jmp      = 1'b0;
        jmp_addr = '0;
        check({tag, "_retire"}, 32'(Run), 0);
    endtask

    initial begin
        // Reset state
        Resetn = 1'b0;
        step();
        step();
        check("rst_pc", 32'(pc), 0);
        check("rst_din", 32'(DIN), 0);
        check("rst_run", 32'(Run), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_icount", 32'(icount), 0);
        check("rst_busy", 32'(busy), 0);
        Resetn = 1'b1;
        step();

        // Basic program 046, 0C9, HALT
        load(6'd0, 9'h046);
        load(6'd1, 9'h0C9);
        load(6'd2, HW);
        load(6'd63, 9'h033);
        pulse_start();
        check("fetch_busy", 32'(busy), 1);
        check("fetch_run", 32'(Run), 0);
        step();
        check("p0_run", 32'(Run), 1);
        check("p0_din", 32'(DIN), 'h46);
        check("p0_pc", 32'(pc), 0);
        check("p0_icount", 32'(icount), 0);
        load_en = 1'b1; load_addr = 6'd0; load_data = 9'h1FF;   // must be ignored in EXEC
        step();
        load_en = 1'b0;
        step();
        check("p0_hold", 32'({Run, DIN}), 'h246);
        done = 1'b1;
        step();
        done = 1'b0;
        check("p0_ret_run", 32'(Run), 0);
        check("p0_ret_pc", 32'(pc), 1);
        check("p0_ret_icount", 32'(icount), 1);
        step();
        check("p1_din", 32'(DIN), 'hC9);
        start = 1'b1;                                            // ignored in EXEC
        step();
        start = 1'b0;
        check("p1_start_ign", 32'({Run, pc, icount}), 32'({1'b1, 6'd1, 8'd1}));
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("p1_ret_pc", 32'(pc), 2);
        check("p1_ret_icount", 32'(icount), 2);
        step();
        check("halt_halted", 32'(halted), 1);
        check("halt_run", 32'(Run), 0);
        check("halt_pc", 32'(pc), 2);
        check("halt_busy", 32'(busy), 0);
        done = 1'b1; jmp = 1'b1; jmp_addr = 6'd9;                // ignored in HALT
        step();
        step();
        done = 1'b0; jmp = 1'b0; jmp_addr = '0;
        check("halt_persist", 32'({halted, busy, pc, icount}), 32'({1'b1, 1'b0, 6'd2, 8'd2}));

        // Restart: original mem[0] survives the EXEC-time write
        pulse_start();
        check("restart_clear", 32'({halted, pc, icount}), 0);
        step();
        check("ignored_load", 32'(DIN), 'h46);
        check("ignored_load_run", 32'(Run), 1);

        // Reset mid-EXEC
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        check("midrst_run", 32'(Run), 0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_din", 32'(DIN), 0);
        done = 1'b1;                                             // ignored in IDLE
        step();
        step();
        step();
        done = 1'b0;
        check("idle_no_fetch", 32'({busy, Run, pc}), 0);
        pulse_start();
        run_instr("rerun0", 9'h046, 6'd0, 1'b0, 6'd0);
        run_instr("rerun1", 9'h0C9, 6'd1, 1'b0, 6'd0);
        step();
        check("rerun_halt", 32'({halted, pc}), 32'({1'b1, 6'd2}));

        // Jump to a HALT word
        load(6'd0, 9'h001);
        load(6'd5, HW);
        pulse_start();
        run_instr("jmp0", 9'h001, 6'd0, 1'b1, 6'd5);
        check("jmp_pc", 32'(pc), 5);
        check("jmp_icount", 32'(icount), 1);
        step();
        check("jmp_halt", 32'({halted, Run, pc}), 32'({1'b1, 1'b0, 6'd5}));

        // Simultaneous load + start, then pc wrap from 63
        load_en = 1'b1; load_addr = 6'd0; load_data = 9'h0AB; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        step();
        check("ldstart_din", 32'(DIN), 'hAB);
        check("ldstart_run", 32'(Run), 1);
        done = 1'b1; jmp = 1'b1; jmp_addr = 6'd63;
        step();
        done = 1'b0; jmp = 1'b0; jmp_addr = '0;
        check("to63_pc", 32'(pc), 63);
        run_instr("pc63", 9'h033, 6'd63, 1'b0, 6'd0);
        check("wrap_pc", 32'(pc), 0);
        check("wrap_icount", 32'(icount), 2);
        step();
        check("wrap_fetch", 32'({Run, DIN, pc}), 32'({1'b1, 9'h0AB, 6'd0}));

        // Saturating instruction count: done held, jump to 0 every time
        done = 1'b1; jmp = 1'b1; jmp_addr = 6'd0;
        repeat (20) step();
        check("loop_icount12", 32'(icount), 12);
        repeat (600) step();
        check("loop_sat", 32'(icount), 255);
        jmp_addr = 6'd5;
        step();
        done = 1'b0; jmp = 1'b0; jmp_addr = '0;
        check("sat_pc5", 32'(pc), 5);
        step();
        check("sat_halt", 32'({halted, Run, icount}), 32'({1'b1, 1'b0, 8'd255}));
        done = 1'b1; jmp = 1'b1; jmp_addr = 6'd9;
        step();
        step();
        done = 1'b0; jmp = 1'b0; jmp_addr = '0;
        check("sat_done_ign", 32'({busy, pc, icount}), 32'({1'b0, 6'd5, 8'd255}));
        pulse_start();
        check("sat_restart", 32'({halted, icount, pc}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
